// File: rtl/sdcard_sample_tuning_controller_if.sv
// Control/status and PHY probe handshake bundle for the SD sample-point tuning controller.
interface sdcard_sample_tuning_controller_if #(
    parameter int unsigned TAP_W      = 5,
    parameter int unsigned HIST_DEPTH = 4
);
    localparam int unsigned HW = $clog2(HIST_DEPTH);

    logic             tune_start_i;
    logic             tune_abort_i;
    logic             probe_pass_i;
    logic             probe_done_i;
    logic             err_event_i;
    logic [HW-1:0]    hist_idx_i;
    logic [TAP_W-1:0] tap_o;
    logic             probe_req_o;
    logic             tune_busy_o;
    logic             tune_done_o;
    logic             tune_fail_o;
    logic             tuned_o;
    logic [TAP_W-1:0] best_tap_o;
    logic [TAP_W:0]   win_len_o;
    logic [TAP_W-1:0] hist_data_o;
    logic [HW:0]      hist_count_o;

    modport master (
        output tune_start_i, tune_abort_i, probe_pass_i, probe_done_i, err_event_i, hist_idx_i,
        input  tap_o, probe_req_o, tune_busy_o, tune_done_o, tune_fail_o, tuned_o,
               best_tap_o, win_len_o, hist_data_o, hist_count_o
    );

    modport slave (
        input  tune_start_i, tune_abort_i, probe_pass_i, probe_done_i, err_event_i, hist_idx_i,
        output tap_o, probe_req_o, tune_busy_o, tune_done_o, tune_fail_o, tuned_o,
               best_tap_o, win_len_o, hist_data_o, hist_count_o
    );
endinterface

// File: rtl/sdcard_sample_tuning_controller.sv
// Sweeps the receive-sample delay tap, finds the widest passing window and programs its centre;
// retries on failure/timeout and re-tunes automatically after a burst of data-path errors.
module sdcard_sample_tuning_controller #(
    parameter int unsigned TAP_W         = 5,
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned PROBE_TIMEOUT = 1024,
    parameter int unsigned MAX_RETRIES   = 4,
    parameter int unsigned ERR_THRESH    = 8,
    parameter int unsigned HIST_DEPTH    = 4
) (
    input  logic                                PCLK_i,
    input  logic                                PRESETn_i,
    sdcard_sample_tuning_controller_if.slave    bus
);
    localparam int unsigned HW      = $clog2(HIST_DEPTH);
    localparam int unsigned AW      = $clog2(MAX_RETRIES + 1);
    localparam int unsigned CNT_MAX = (SETTLE_CYCLES > PROBE_TIMEOUT) ? SETTLE_CYCLES : PROBE_TIMEOUT;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {IDLE, SET_TAP, SETTLE, PROBE, EVAL, SELECT, DONE, RETRY} state_e;

    state_e           state_q;
    logic [TAP_W-1:0] cur_tap_q, run_start_q, best_start_q, centre_q;
    logic [TAP_W:0]   run_len_q, best_len_q;
    logic [CNT_W-1:0] cnt_q;
    logic [AW-1:0]    attempts_q;
    logic [7:0]       err_cnt_q;
    logic             auto_pending_q, pass_q;
    logic [TAP_W-1:0] tap_q, best_tap_q;
    logic             req_q, busy_q, done_q, fail_q, tuned_q;
    logic [TAP_W:0]   win_len_q;
    logic [TAP_W-1:0] hist_q [HIST_DEPTH];
    logic [HW-1:0]    wr_ptr_q;
    logic [HW:0]      hist_cnt_q;

    logic [TAP_W:0]   run_inc_d, half_d;
    logic [TAP_W-1:0] centre_d;
    logic [AW-1:0]    attempts_d;
    logic [7:0]       err_cnt_d;
    logic [HW-1:0]    rd_ptr_d;

    assign run_inc_d  = run_len_q + (TAP_W+1)'(1);
    // Half-width fits in TAP_W bits, so the centre never overflows the tap range.
    assign half_d     = (best_len_q - (TAP_W+1)'(1)) >> 1;
    assign centre_d   = best_start_q + TAP_W'(half_d);
    assign attempts_d = attempts_q + AW'(1);
    assign err_cnt_d  = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
    assign rd_ptr_d   = wr_ptr_q - HW'(1) - bus.hist_idx_i;

    always_ff @(posedge PCLK_i or negedge PRESETn_i) begin
        if (!PRESETn_i) begin
            state_q        <= IDLE;
            cur_tap_q      <= '0;
            run_start_q    <= '0;
            best_start_q   <= '0;
            centre_q       <= '0;
            run_len_q      <= '0;
            best_len_q     <= '0;
            cnt_q          <= '0;
            attempts_q     <= '0;
            err_cnt_q      <= '0;
            auto_pending_q <= 1'b0;
            pass_q         <= 1'b0;
            tap_q          <= '0;
            best_tap_q     <= '0;
            req_q          <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            fail_q         <= 1'b0;
            tuned_q        <= 1'b0;
            win_len_q      <= '0;
            wr_ptr_q       <= '0;
            hist_cnt_q     <= '0;
            for (int unsigned i = 0; i < HIST_DEPTH; i++) hist_q[i] <= '0;
        end else begin
            done_q <= 1'b0;
            fail_q <= 1'b0;
            if (state_q != IDLE && bus.tune_abort_i) begin
                state_q        <= IDLE;
                busy_q         <= 1'b0;
                req_q          <= 1'b0;
                tap_q          <= best_tap_q;
                auto_pending_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (tuned_q && bus.err_event_i) begin
                            err_cnt_q <= err_cnt_d;
                            if (err_cnt_d >= 8'(ERR_THRESH)) auto_pending_q <= 1'b1;
                        end
                        // Later assignments here override the error accounting above.
                        if (bus.tune_start_i || auto_pending_q) begin
                            state_q        <= SET_TAP;
                            busy_q         <= 1'b1;
                            cur_tap_q      <= '0;
                            run_len_q      <= '0;
                            best_len_q     <= '0;
                            attempts_q     <= '0;
                            err_cnt_q      <= '0;
                            auto_pending_q <= 1'b0;
                        end
                    end
                    SET_TAP: begin
                        tap_q   <= cur_tap_q;
                        cnt_q   <= CNT_W'(SETTLE_CYCLES);
                        state_q <= SETTLE;
                    end
                    SETTLE: begin
                        cnt_q <= cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) begin
                            state_q <= PROBE;
                            req_q   <= 1'b1;
                            cnt_q   <= CNT_W'(PROBE_TIMEOUT);
                        end
                    end
                    PROBE: begin
                        if (bus.probe_done_i) begin
                            pass_q  <= bus.probe_pass_i;
                            req_q   <= 1'b0;
                            state_q <= EVAL;
                        end else if (cnt_q == CNT_W'(1)) begin
                            req_q   <= 1'b0;
                            state_q <= RETRY;
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                    EVAL: begin
                        if (pass_q) begin
                            if (run_len_q == '0) run_start_q <= cur_tap_q;
                            run_len_q <= run_inc_d;
                            if (run_inc_d > best_len_q) begin
                                best_len_q   <= run_inc_d;
                                best_start_q <= (run_len_q == '0) ? cur_tap_q : run_start_q;
                            end
                        end else begin
                            run_len_q <= '0;
                        end
                        if (&cur_tap_q) begin
                            state_q <= SELECT;
                        end else begin
                            cur_tap_q <= cur_tap_q + TAP_W'(1);
                            state_q   <= SET_TAP;
                        end
                    end
                    SELECT: begin
                        if (best_len_q == '0) begin
                            state_q <= RETRY;
                        end else begin
                            centre_q <= centre_d;
                            state_q  <= DONE;
                        end
                    end
                    DONE: begin
                        tap_q            <= centre_q;
                        best_tap_q       <= centre_q;
                        win_len_q        <= best_len_q;
                        tuned_q          <= 1'b1;
                        done_q           <= 1'b1;
                        hist_q[wr_ptr_q] <= centre_q;
                        wr_ptr_q         <= wr_ptr_q + HW'(1);
                        if (hist_cnt_q != (HW+1)'(HIST_DEPTH)) hist_cnt_q <= hist_cnt_q + (HW+1)'(1);
                        busy_q           <= 1'b0;
                        state_q          <= IDLE;
                    end
                    RETRY: begin
                        attempts_q <= attempts_d;
                        if (attempts_d < AW'(MAX_RETRIES)) begin
                            cur_tap_q  <= '0;
                            run_len_q  <= '0;
                            best_len_q <= '0;
                            state_q    <= SET_TAP;
                        end else begin
                            fail_q  <= 1'b1;
                            tuned_q <= 1'b0;
                            tap_q   <= best_tap_q;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.tap_o        = tap_q;
    assign bus.probe_req_o  = req_q;
    assign bus.tune_busy_o  = busy_q;
    assign bus.tune_done_o  = done_q;
    assign bus.tune_fail_o  = fail_q;
    assign bus.tuned_o      = tuned_q;
    assign bus.best_tap_o   = best_tap_q;
    assign bus.win_len_o    = win_len_q;
    assign bus.hist_data_o  = hist_q[rd_ptr_d];
    assign bus.hist_count_o = hist_cnt_q;
endmodule

// File: tb/tb_sdcard_sample_tuning_controller.sv
// Directed bench for the sample tuning controller: 8 taps, short settle/timeout, 2 retries.
module tb_sdcard_sample_tuning_controller;
    logic clk;
    logic rst_n;

    sdcard_sample_tuning_controller_if #(.TAP_W(3), .HIST_DEPTH(4)) bus ();

    sdcard_sample_tuning_controller #(
        .TAP_W(3), .SETTLE_CYCLES(2), .PROBE_TIMEOUT(8),
        .MAX_RETRIES(2), .ERR_THRESH(3), .HIST_DEPTH(4)
    ) dut (
        .PCLK_i   (clk),
        .PRESETn_i(rst_n),
        .bus      (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] pass_mask = 8'h00;
    logic       hang_en   = 1'b0;
    logic [2:0] hang_tap  = 3'd0;
    int         cyc = 0, done_cnt = 0, fail_cnt = 0, req_cnt = 0;
    int         last_rise = 0, prev_rise = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Probe engine model: answers in the same cycle unless the tap is configured to hang.
    initial begin
        bus.probe_done_i = 1'b0;
        bus.probe_pass_i = 1'b0;
        forever begin
            @(negedge clk);
            bus.probe_done_i = bus.probe_req_o && !(hang_en && bus.tap_o == hang_tap);
            bus.probe_pass_i = pass_mask[bus.tap_o];
        end
    end

    initial begin
        logic req_prev;
        req_prev = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (bus.tune_done_o) done_cnt++;
            if (bus.tune_fail_o) fail_cnt++;
            if (bus.probe_req_o && !req_prev) begin
                req_cnt++;
                prev_rise = last_rise;
                last_rise = cyc;
            end
            req_prev = bus.probe_req_o;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got 0 expected 1");
        $fatal(1);
    end

    task automatic pulse_start();
        @(negedge clk);
        bus.tune_start_i = 1'b1;
        @(negedge clk);
        bus.tune_start_i = 1'b0;
    endtask

    task automatic wait_end(input string tag, output int n);
        n = 1;
        while (!bus.tune_done_o && !bus.tune_fail_o && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(n < 2000), 1);
    endtask

    task automatic run_tune(input logic [7:0] m, output int n);
        pass_mask = m;
        pulse_start();
        wait_end("run_bound", n);
    endtask

    task automatic chk_hist(input string tag, input logic [1:0] idx, input logic [2:0] exp);
        bus.hist_idx_i = idx;
        #1;
        chk(tag, 32'(bus.hist_data_o), 32'(exp));
    endtask

    initial begin
        int n, r0, d0, f0, hi;
        bus.tune_start_i = 1'b0;
        bus.tune_abort_i = 1'b0;
        bus.err_event_i  = 1'b0;
        bus.hist_idx_i   = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tap",   32'(bus.tap_o), 0);
        chk("rst_req",   32'(bus.probe_req_o), 0);
        chk("rst_busy",  32'(bus.tune_busy_o), 0);
        chk("rst_done",  32'(bus.tune_done_o), 0);
        chk("rst_fail",  32'(bus.tune_fail_o), 0);
        chk("rst_tuned", 32'(bus.tuned_o), 0);
        chk("rst_best",  32'(bus.best_tap_o), 0);
        chk("rst_win",   32'(bus.win_len_o), 0);
        chk("rst_hcnt",  32'(bus.hist_count_o), 0);
        chk_hist("rst_hdata", 2'd0, 3'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Window 2..6: centre 4, width 5.
        r0 = req_cnt; d0 = done_cnt;
        run_tune(8'b0111_1100, n);
        chk("t1_latency", 32'(n), 43);
        chk("t1_done",    32'(bus.tune_done_o), 1);
        chk("t1_best",    32'(bus.best_tap_o), 4);
        chk("t1_win",     32'(bus.win_len_o), 5);
        chk("t1_tuned",   32'(bus.tuned_o), 1);
        chk("t1_tap",     32'(bus.tap_o), 4);
        chk("t1_busy",    32'(bus.tune_busy_o), 0);
        @(negedge clk);
        chk("t1_done_low", 32'(bus.tune_done_o), 0);
        chk("t1_reqs",    32'(req_cnt - r0), 8);
        chk("t1_spacing", 32'(last_rise - prev_rise), 5);
        chk("t1_pulses",  32'(done_cnt - d0), 1);
        chk("t1_hcnt",    32'(bus.hist_count_o), 1);
        chk_hist("t1_hist0", 2'd0, 3'd4);

        // Windows 1..4 and 6..7: widest wins.
        run_tune(8'b1101_1110, n);
        chk("t2_best", 32'(bus.best_tap_o), 2);
        chk("t2_win",  32'(bus.win_len_o), 4);

        // Equal windows 0..1 and 4..5: lower one kept.
        run_tune(8'b0011_0011, n);
        chk("t3_best", 32'(bus.best_tap_o), 0);
        chk("t3_win",  32'(bus.win_len_o), 2);

        run_tune(8'b0111_1100, n);
        chk("t4_best", 32'(bus.best_tap_o), 4);
        chk("t4_hcnt", 32'(bus.hist_count_o), 4);

        // All taps fail: two sweeps then failure, tap restored to previous best.
        @(negedge clk);
        r0 = req_cnt; d0 = done_cnt; f0 = fail_cnt;
        run_tune(8'h00, n);
        chk("f_fail",    32'(bus.tune_fail_o), 1);
        chk("f_latency", 32'(n), 85);
        chk("f_tuned",   32'(bus.tuned_o), 0);
        chk("f_tap",     32'(bus.tap_o), 4);
        chk("f_best",    32'(bus.best_tap_o), 4);
        chk("f_win",     32'(bus.win_len_o), 5);
        chk("f_hcnt",    32'(bus.hist_count_o), 4);
        @(negedge clk);
        chk("f_reqs",    32'(req_cnt - r0), 16);
        chk("f_pulses",  32'(fail_cnt - f0), 1);
        chk("f_nodone",  32'(done_cnt - d0), 0);

        // Probe never completes at tap 3: request held 8 cycles, then sweep restarts at tap 0.
        pass_mask = 8'hFF; hang_tap = 3'd3; hang_en = 1'b1;
        pulse_start();
        n = 0;
        while (!(bus.probe_req_o && bus.tap_o == 3'd3) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("to_reach", 32'(n < 500), 1);
        hi = 0;
        while (bus.probe_req_o && hi < 100) begin
            hi++;
            @(negedge clk);
        end
        chk("to_req_len", 32'(hi), 8);
        hang_en = 1'b0;
        chk("to_busy", 32'(bus.tune_busy_o), 1);
        n = 0;
        while (!bus.probe_req_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("to_restart_tap", 32'(bus.tap_o), 0);
        wait_end("to_bound", n);
        chk("to_done",  32'(bus.tune_done_o), 1);
        chk("to_best",  32'(bus.best_tap_o), 3);
        chk("to_win",   32'(bus.win_len_o), 8);
        chk("to_hcnt",  32'(bus.hist_count_o), 4);
        chk_hist("h_idx0", 2'd0, 3'd3);
        chk_hist("h_idx1", 2'd1, 3'd4);
        chk_hist("h_idx2", 2'd2, 3'd0);
        chk_hist("h_idx3", 2'd3, 3'd2);

        // Abort mid-sweep at tap 5 after a success at 4.
        run_tune(8'b0111_1100, n);
        chk("ab_pre_best", 32'(bus.best_tap_o), 4);
        pass_mask = 8'hFF;
        @(negedge clk);
        d0 = done_cnt; f0 = fail_cnt;
        pulse_start();
        n = 0;
        while (bus.tap_o != 3'd5 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("ab_reach", 32'(n < 500), 1);
        bus.tune_abort_i = 1'b1;
        @(negedge clk);
        bus.tune_abort_i = 1'b0;
        chk("ab_busy",  32'(bus.tune_busy_o), 0);
        chk("ab_tap",   32'(bus.tap_o), 4);
        chk("ab_req",   32'(bus.probe_req_o), 0);
        chk("ab_tuned", 32'(bus.tuned_o), 1);
        chk("ab_best",  32'(bus.best_tap_o), 4);
        chk("ab_hcnt",  32'(bus.hist_count_o), 4);
        repeat (3) @(negedge clk);
        chk("ab_nodone", 32'(done_cnt - d0), 0);
        chk("ab_nofail", 32'(fail_cnt - f0), 0);
        chk("ab_idle",   32'(bus.tune_busy_o), 0);
        chk_hist("ab_hist0", 2'd0, 3'd4);

        // Auto re-tune: two errors stay below threshold, the third triggers a sweep.
        pass_mask = 8'b0111_1100;
        bus.err_event_i = 1'b1;
        @(negedge clk);
        bus.err_event_i = 1'b0;
        @(negedge clk);
        bus.err_event_i = 1'b1;
        @(negedge clk);
        bus.err_event_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("ar_below", 32'(bus.tune_busy_o), 0);
        bus.err_event_i = 1'b1;
        @(negedge clk);
        bus.err_event_i = 1'b0;
        @(negedge clk);
        chk("ar_busy", 32'(bus.tune_busy_o), 1);
        wait_end("ar_bound", n);
        chk("ar_done", 32'(bus.tune_done_o), 1);
        chk("ar_best", 32'(bus.best_tap_o), 4);

        // Reset while a probe is outstanding.
        hang_en = 1'b1; hang_tap = 3'd0; pass_mask = 8'hFF;
        pulse_start();
        n = 0;
        while (!bus.probe_req_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("mr_reach", 32'(bus.probe_req_o), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_req",   32'(bus.probe_req_o), 0);
        chk("mr_busy",  32'(bus.tune_busy_o), 0);
        chk("mr_tuned", 32'(bus.tuned_o), 0);
        chk("mr_best",  32'(bus.best_tap_o), 0);
        chk("mr_hcnt",  32'(bus.hist_count_o), 0);
        @(negedge clk);
        hang_en = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/sdcard_sample_tuning_controller.md
Name: sdcard_sample_tuning_controller

Overview:
Parametrised sample-point tuning engine for the SD card data path. It sweeps a receive-sample delay tap across all positions and requests a probe transfer at each tap. It then locates the widest contiguous passing window and programs its centre tap. It adds per-tap timeout, bounded retries, automatic re-tuning on CRC error bursts, and a result history buffer. It sits between the APB register block (start/abort/status) and the PHY delay line / probe engine.

Parameters:
TAP_W, 5, tap index width; NUM_TAPS = 2**TAP_W
SETTLE_CYCLES, 16, cycles waited after each tap change before probing (>=1)
PROBE_TIMEOUT, 1024, max cycles waiting for probe_done_i per tap (>=1)
MAX_RETRIES, 4, full sweeps attempted before failure (>=1)
ERR_THRESH, 8, err_event_i count that triggers auto re-tune (1..255)
HIST_DEPTH, 4, result history entries (power of 2, >=2)

Ports:
PCLK_i  in  1  clock
PRESETn_i  in  1  asynchronous active-low reset
tune_start_i  in  1  start pulse; ignored while busy
tune_abort_i  in  1  abort current tuning
probe_pass_i  in  1  probe result, valid with probe_done_i
probe_done_i  in  1  probe completion strobe
err_event_i  in  1  one data-path CRC/timeout error per cycle asserted
hist_idx_i  in  $clog2(HIST_DEPTH)  history read index, 0 = newest
tap_o  out  TAP_W  delay tap driven to PHY
probe_req_o  out  1  probe request level, held until probe_done_i
tune_busy_o  out  1  high in every state except IDLE
tune_done_o  out  1  one-cycle success pulse
tune_fail_o  out  1  one-cycle failure pulse
tuned_o  out  1  a valid tap is programmed
best_tap_o  out  TAP_W  last successful centre tap
win_len_o  out  TAP_W+1  width of last successful window
hist_data_o  out  TAP_W  combinational read of history entry hist_idx_i
hist_count_o  out  $clog2(HIST_DEPTH)+1  valid entries, saturating at HIST_DEPTH

Behaviour:
- Reset: all outputs 0. State IDLE; attempts, err_cnt, history pointer and counters 0; history entries 0.
- States: IDLE, SET_TAP, SETTLE, PROBE, EVAL, SELECT, DONE, RETRY.
- IDLE: go to SET_TAP when tune_start_i is high or auto_pending is set. Entry clears cur_tap, run_len, best_len, attempts and err_cnt.
- SET_TAP (1 cycle): tap_o <= cur_tap; load settle counter with SETTLE_CYCLES.
- SETTLE: decrement the counter. At 0, go to PROBE; probe_req_o goes high and the timeout counter loads PROBE_TIMEOUT.
- PROBE: on probe_done_i, capture probe_pass_i, drop probe_req_o and go to EVAL. On timeout expiry without done, drop probe_req_o and go to RETRY.
- EVAL (1 cycle):
  - On pass: if run_len == 0, run_start <= cur_tap; then run_len++.
  - If the new run_len > best_len (strictly), update best_start and best_len. Ties keep the lower window.
  - On fail: run_len <= 0.
  - If cur_tap == NUM_TAPS-1, go to SELECT. Otherwise cur_tap++ and go to SET_TAP.
- SELECT: if best_len == 0, go to RETRY. Otherwise centre = best_start + ((best_len-1) >> 1), computed at TAP_W+1 bits (cannot overflow), then go to DONE.
- DONE (1 cycle):
  - tap_o, best_tap_o <= centre; win_len_o <= best_len.
  - tuned_o <= 1; tune_done_o pulses.
  - Write centre to history at wr_ptr, wr_ptr++ (wraps modulo HIST_DEPTH).
  - Go to IDLE.
- RETRY:
  - attempts++.
  - If attempts < MAX_RETRIES: clear sweep trackers and cur_tap, go to SET_TAP.
  - Else: tune_fail_o pulses, tuned_o <= 0, tap_o <= best_tap_o (previous good value, 0 if none), go to IDLE.
- Per-tap latency with immediate probe_done_i: SETTLE_CYCLES+3 cycles. Full successful sweep: NUM_TAPS*(SETTLE_CYCLES+3)+2 cycles from the first SET_TAP to the DONE pulse.
- Abort: tune_abort_i in any non-IDLE state returns the block to IDLE next cycle.
  - probe_req_o <= 0; tap_o <= best_tap_o.
  - No done/fail pulse; tuned_o, best_tap_o and history are unchanged.
  - Abort has priority over probe_done_i in the same cycle. Abort in IDLE has no effect; tune_start_i then proceeds normally.
- Auto re-tune: while tuned_o && IDLE, each err_event_i increments err_cnt (saturating 8-bit). When err_cnt reaches ERR_THRESH, auto_pending sets; the next cycle in IDLE starts tuning exactly as tune_start_i does.
- err_event_i is ignored while busy. auto_pending clears on sweep start and on abort.
- hist_data_o = entry[(wr_ptr-1-hist_idx_i) mod HIST_DEPTH]. Indexes >= hist_count_o return stale or zero data and are not checked.
- Reset asserted mid-operation: immediate return to reset values; probe_req_o deasserts asynchronously.

Test Plan:
- TAP_W=3, SETTLE_CYCLES=2; taps 2..6 pass -> tune_done_o pulse, best_tap_o=4, win_len_o=5, tuned_o=1; per-tap spacing is 5 cycles with immediate done.
- Taps 1..4 pass and 6..7 pass -> best_tap_o=2, win_len_o=4. Windows 0..1 and 4..5 only -> best_tap_o=0 (tie keeps the lower window).
- All taps fail, MAX_RETRIES=2 -> exactly 2 sweeps (16 probe requests), then tune_fail_o pulse; tuned_o=0; tap_o restored to the previous best_tap_o.
- PROBE_TIMEOUT=8, probe_done_i never asserted at tap 3 -> probe_req_o drops after 8 cycles, attempts=1, sweep restarts at tap 0.
- tune_abort_i during tap 5 of a sweep after an earlier success at 4 -> IDLE next cycle; tap_o=4; no pulses; tuned_o stays 1; hist_count_o unchanged.
- ERR_THRESH=3, tuned: three err_event_i pulses -> tune_busy_o rises within 2 cycles. Five successful tunings with HIST_DEPTH=4 -> hist_count_o=4, hist_idx_i=0 returns the newest result and hist_idx_i=3 the second result.
